coin_credit_bank: RTL and testbench

COIN_CREDIT_BANK -- requirements
Module: coin_credit_bank

---
 rtl/coin_credit_bank.sv | 117 +++++++++++
 tb/tb_coin_credit_bank.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/coin_credit_bank.sv
// Coin acceptor and game credit bank: converts coins into paid games plus leftover credit.
// Optional COIN_DEBOUNCE_EN adds a QUALIFY state requiring a two-cycle stable coin before acceptance.
module coin_credit_bank #(
  parameter int GAME_COST = 4,
  parameter int MAX_GAMES = 7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] CoinValue,
  input  logic       CoinInserted,
  input  logic       consumeGame,
  output logic [3:0] NumGames,
  output logic [1:0] credit,
  output logic       drop,
  output logic       gameAvailable
);

`ifdef COIN_DEBOUNCE_EN
  typedef enum logic [1:0] {IDLE, QUALIFY, ACCEPT, WAIT_RELEASE} state_t;
`else
  typedef enum logic [1:0] {IDLE, ACCEPT, WAIT_RELEASE} state_t;
`endif

  localparam logic [3:0] COST = 4'(GAME_COST);
  localparam logic [4:0] LIMIT = 5'(MAX_GAMES);

  state_t     state, nextState;
  logic       prevInserted;
  logic       rise;
  logic       accept;
  logic [1:0] coinSel;
  logic [3:0] coinZm, sum, gamesAdd, afterConsume;
  logic [4:0] total;

`ifdef COIN_DEBOUNCE_EN
  logic [1:0] heldValue;
  assign coinSel = heldValue;
`else
  assign coinSel = CoinValue;
`endif

  // A coin qualifies only on a fresh insertion; value 00 never leaves IDLE.
  assign rise = CoinInserted && !prevInserted && (CoinValue != 2'b00);

  always_comb begin
    nextState = state;
    accept    = 1'b0;
    case (state)
      IDLE: if (rise) begin
`ifdef COIN_DEBOUNCE_EN
        nextState = QUALIFY;
`else
        nextState = ACCEPT;
        accept    = 1'b1;
`endif
      end
`ifdef COIN_DEBOUNCE_EN
      QUALIFY: begin
        if (CoinInserted && (CoinValue == heldValue)) begin
          nextState = ACCEPT;
          accept    = 1'b1;
        end else begin
          nextState = IDLE;
        end
      end
`endif
      ACCEPT:       nextState = WAIT_RELEASE;
      WAIT_RELEASE: if (!CoinInserted) nextState = IDLE;
      default:      nextState = IDLE;
    endcase
  end

  always_comb begin
    coinZm = 4'd0;
    case (coinSel)
      2'b01:   coinZm = 4'd1;
      2'b10:   coinZm = 4'd3;
      2'b11:   coinZm = 4'd5;
      default: coinZm = 4'd0;
    endcase
  end

  // Decrement is applied before the saturating add so a same-cycle consume frees a slot.
  assign sum          = {2'b00, credit} + coinZm;
  assign gamesAdd     = sum / COST;
  assign afterConsume = (consumeGame && NumGames != 4'd0) ? NumGames - 4'd1 : NumGames;
  assign total        = {1'b0, afterConsume} + {1'b0, gamesAdd};

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      prevInserted <= 1'b1;
      NumGames     <= 4'd0;
      credit       <= 2'd0;
      drop         <= 1'b0;
`ifdef COIN_DEBOUNCE_EN
      heldValue    <= 2'b00;
`endif
    end else begin
      state        <= nextState;
      prevInserted <= CoinInserted;
      drop         <= accept && (gamesAdd != 4'd0);
`ifdef COIN_DEBOUNCE_EN
      if (state == IDLE) heldValue <= CoinValue;
`endif
      if (accept) begin
        credit   <= 2'(sum % COST);
        NumGames <= (total > LIMIT) ? LIMIT[3:0] : total[3:0];
      end else begin
        NumGames <= afterConsume;
      end
    end
  end

  assign gameAvailable = (NumGames != 4'd0);

endmodule

// File: tb/tb_coin_credit_bank.sv
// Self-checking bench for coin_credit_bank: arithmetic reference model checked every cycle,
// plus literal expectations after each directed scenario (COIN_DEBOUNCE_EN adds glitch tests).
module tb_coin_credit_bank;
  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] CoinValue;
  logic       CoinInserted;
  logic       consumeGame;
  logic [3:0] NumGames;
  logic [1:0] credit;
  logic       drop;
  logic       gameAvailable;

  int checks = 0;
  int errors = 0;
  int drops  = 0;

  int   mNum, mCred;
  bit   mDrop;
  bit   p1, p2;
  logic [1:0] pv;

  coin_credit_bank dut (
    .clock(clock), .reset(reset), .CoinValue(CoinValue), .CoinInserted(CoinInserted),
    .consumeGame(consumeGame), .NumGames(NumGames), .credit(credit), .drop(drop),
    .gameAvailable(gameAvailable)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int zork(input logic [1:0] v);
    case (v)
      2'b01:   return 1;
      2'b10:   return 3;
      2'b11:   return 5;
      default: return 0;
    endcase
  endfunction

  // Reference: a coin counts once per fresh insertion; games = sum/4, leftover = sum%4, cap 7.
  always @(posedge clock) begin
    bit acc;
    int s, g;
    if (reset) begin
      mNum = 0; mCred = 0; mDrop = 0; p1 = 1; p2 = 1; pv = 2'b00;
    end else begin
`ifdef COIN_DEBOUNCE_EN
      acc = CoinInserted && p1 && !p2 && (CoinValue == pv) && (CoinValue != 2'b00);
`else
      acc = CoinInserted && !p1 && (CoinValue != 2'b00);
`endif
      if (consumeGame && mNum > 0) mNum = mNum - 1;
      mDrop = 0;
      if (acc) begin
        s = mCred + zork(CoinValue);
        g = s / 4;
        mCred = s % 4;
        mNum = (mNum + g > 7) ? 7 : mNum + g;
        mDrop = (g > 0);
      end
      p2 = p1; p1 = CoinInserted; pv = CoinValue;
    end
  end

  always @(negedge clock) begin
    chk("NumGames", NumGames, mNum);
    chk("credit", credit, mCred);
    chk("drop", drop, mDrop);
    chk("gameAvailable", gameAvailable, mNum != 0);
    if (drop) drops++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic coin(input logic [1:0] v, input int hold, input bit cons);
    CoinValue = v; CoinInserted = 1'b1; consumeGame = cons;
    step(1);
    consumeGame = 1'b0;
    if (hold > 1) step(hold - 1);
    CoinInserted = 1'b0;
    step(4);
  endtask

  task automatic doReset();
    reset = 1'b1; step(1); reset = 1'b0; step(1);
  endtask

  task automatic expect2(input string name, input int n, input int c);
    chk({name, ".NumGames"}, NumGames, n);
    chk({name, ".credit"}, credit, c);
  endtask

  initial begin
    reset = 1'b1; CoinValue = 2'b00; CoinInserted = 1'b0; consumeGame = 1'b0;
    step(2);
    reset = 1'b0;
    step(1);
    expect2("reset", 0, 0);
    chk("reset.drop", drop, 0);
    chk("reset.avail", gameAvailable, 0);

    // circle then triangle completes one game
    drops = 0;
    coin(2'b01, 2, 0);
    coin(2'b10, 2, 0);
    expect2("circTri", 1, 0);
    chk("circTri.drops", drops, 1);
    chk("circTri.avail", gameAvailable, 1);
    consumeGame = 1'b1; step(1); consumeGame = 1'b0; step(1);
    chk("consume.NumGames", NumGames, 0);

    // long-held triangle counts once
    drops = 0;
    coin(2'b10, 5, 0);
    coin(2'b10, 2, 0);
    expect2("heldTri", 1, 2);
    chk("heldTri.drops", drops, 1);

    // value change while held and a 00 coin are both ignored
    doReset();
    CoinValue = 2'b10; CoinInserted = 1'b1; step(2);
    CoinValue = 2'b11; step(3);
    CoinInserted = 1'b0; step(4);
    coin(2'b00, 2, 0);
    expect2("valChange", 0, 3);

    // pentagons and the double-game coin
    doReset();
    coin(2'b11, 2, 0); expect2("pent1", 1, 1);
    coin(2'b11, 2, 0); expect2("pent2", 2, 2);
    coin(2'b01, 2, 0); expect2("circ3", 2, 3);
    drops = 0;
    coin(2'b11, 2, 0); expect2("pentDouble", 4, 0);
    chk("pentDouble.drops", drops, 1);

    // saturation
    coin(2'b11, 2, 0); coin(2'b11, 2, 0); coin(2'b11, 2, 0);
    expect2("fill", 7, 3);
    drops = 0;
    coin(2'b11, 2, 0); expect2("saturate", 7, 0);
    chk("saturate.drops", drops, 1);

    // consume and accept together at the limit
    coin(2'b01, 2, 0); coin(2'b01, 2, 0); coin(2'b01, 2, 0);
    expect2("refill", 7, 3);
    coin(2'b11, 2, 1); expect2("satConsume", 7, 0);

    // no underflow
    doReset();
    consumeGame = 1'b1; step(1); consumeGame = 1'b0; step(1);
    chk("underflow.NumGames", NumGames, 0);
    chk("underflow.avail", gameAvailable, 0);

    // reset while a pentagon is held
    CoinValue = 2'b11; CoinInserted = 1'b1; step(3);
    expect2("preReset", 1, 1);
    reset = 1'b1; step(1); reset = 1'b0; step(1);
    expect2("midCoinReset", 0, 0);
    chk("midCoinReset.drop", drop, 0);
    step(3);
    expect2("stillHeld", 0, 0);
    CoinInserted = 1'b0; step(4);
    coin(2'b01, 2, 0); expect2("reinsert", 0, 1);

    // consume alongside a game-completing circle
    coin(2'b10, 2, 0); expect2("tri4", 1, 0);
    coin(2'b10, 2, 0); expect2("tri3", 1, 3);
    coin(2'b01, 2, 1); expect2("circConsume", 1, 0);

`ifdef COIN_DEBOUNCE_EN
    doReset();
    coin(2'b10, 1, 0); expect2("glitch", 0, 0);
    CoinValue = 2'b10; CoinInserted = 1'b1; step(1);
    CoinValue = 2'b01; step(2);
    CoinInserted = 1'b0; step(4);
    expect2("debValChange", 0, 0);
    coin(2'b10, 2, 0); expect2("debStable", 0, 3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
